pixel_frame_server: RTL and testbench

// Responder side of the CNN image-fetch port: holds 28x28 8-bit frames and answers cnn_top's

---
 rtl/pixel_frame_server.sv | 180 ++++++++++++++++++
 tb/tb_pixel_frame_server.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_server.sv
// Ping-pong 28x28 frame store that feeds cnn_top like a pixel ROM.
// Sequences the CNN reset around each frame and captures its decision.
module pixel_frame_server #(
    parameter int unsigned PIX_W    = 8,
    parameter int unsigned NPIX     = 784,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned RST_HOLD = 4,
    parameter int unsigned WDOG     = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [PIX_W-1:0]  s_data,
    input  logic              s_last,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] addra,
    output logic [PIX_W-1:0]  douta,
    output logic              cnn_rst_n,
    input  logic              cnn_done,
    input  logic [3:0]        decision_in,
    output logic              result_valid,
    output logic [3:0]        result,
    output logic              err_short,
    output logic              err_timeout,
    output logic [15:0]       frames_done
);

    localparam int unsigned PTR_W  = $clog2(NPIX);
    localparam int unsigned WD_W   = (WDOG > 1) ? $clog2(WDOG) : 1;
    localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    logic [PIX_W-1:0]  bank0 [NPIX];
    logic [PIX_W-1:0]  bank1 [NPIX];

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              rd_sel_q, rd_sel_d;
    logic              wr_sel_q, wr_sel_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]        full_q, full_d;
    logic              cnn_done_q;
    logic              done_rise;
    logic              bank_release;
    logic              accept;

    logic              s_ready_d;
    logic              cnn_rst_n_d;
    logic              result_valid_d;
    logic [3:0]        result_d;
    logic              err_short_d;
    logic              err_timeout_d;
    logic [15:0]       frames_done_d;

    assign accept    = s_valid & s_ready;
    assign done_rise = cnn_done & ~cnn_done_q;

    // Read sequencer: hold CNN in reset, run it on a full bank, recover its decision.
    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        wd_d           = wd_q;
        rd_sel_d       = rd_sel_q;
        result_d       = result;
        result_valid_d = 1'b0;
        err_timeout_d  = 1'b0;
        frames_done_d  = frames_done;
        bank_release   = 1'b0;
        case (state_q)
            IDLE: begin
                wd_d = '0;
                if (full_q[rd_sel_q]) state_d = RUN;
            end
            RUN: begin
                if (done_rise) begin
                    result_d       = decision_in;
                    result_valid_d = 1'b1;
                    frames_done_d  = frames_done + 16'd1;
                    bank_release   = 1'b1;
                end else if (WDOG != 0 && wd_q == WD_W'(WDOG - 1)) begin
                    err_timeout_d = 1'b1;
                    bank_release  = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
                if (bank_release) begin
                    rd_sel_d = ~rd_sel_q;
                    hold_d   = '0;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (hold_q == HOLD_W'(RST_HOLD - 1)) state_d = IDLE;
                else hold_d = hold_q + HOLD_W'(1);
            end
            default: state_d = IDLE;
        endcase
        cnn_rst_n_d = (state_d == RUN);
    end

    // Ingest side: fill the write bank, flag short frames, track bank occupancy.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_sel_d    = wr_sel_q;
        full_d      = full_q;
        err_short_d = 1'b0;
        if (accept) begin
            if (wr_ptr_q == PTR_W'(NPIX - 1)) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = ~wr_sel_q;
                wr_ptr_d         = '0;
            end else if (s_last) begin
                err_short_d = 1'b1;
                wr_ptr_d    = '0;
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
        end
        if (bank_release) full_d[rd_sel_q] = 1'b0;
        s_ready_d = ~full_d[wr_sel_d];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            wd_q         <= '0;
            rd_sel_q     <= 1'b0;
            wr_sel_q     <= 1'b0;
            wr_ptr_q     <= '0;
            full_q       <= '0;
            cnn_done_q   <= 1'b0;
            s_ready      <= 1'b0;
            cnn_rst_n    <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            err_short    <= 1'b0;
            err_timeout  <= 1'b0;
            frames_done  <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            wd_q         <= wd_d;
            rd_sel_q     <= rd_sel_d;
            wr_sel_q     <= wr_sel_d;
            wr_ptr_q     <= wr_ptr_d;
            full_q       <= full_d;
            cnn_done_q   <= cnn_done;
            s_ready      <= s_ready_d;
            cnn_rst_n    <= cnn_rst_n_d;
            result_valid <= result_valid_d;
            result       <= result_d;
            err_short    <= err_short_d;
            err_timeout  <= err_timeout_d;
            frames_done  <= frames_done_d;
        end
    end

    // Pixel storage; no reset so the banks map onto plain RAM.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            if (wr_sel_q) bank1[wr_ptr_q] <= s_data;
            else          bank0[wr_ptr_q] <= s_data;
        end
    end

    // ROM-style read port, zero outside RUN or past the frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            douta <= '0;
        end else if (state_q == RUN && addra < ADDR_W'(NPIX)) begin
            douta <= rd_sel_q ? bank1[addra] : bank0[addra];
        end else begin
            douta <= '0;
        end
    end

endmodule

// File: tb/tb_pixel_frame_server.sv
// Randomized bench for pixel_frame_server against a frame-queue model of the store.
module tb_pixel_frame_server;

    localparam int unsigned NPIX     = 784;
    localparam int unsigned RST_HOLD = 4;
    localparam int unsigned WDOG_T   = 50;

    typedef logic [7:0] frame_t [NPIX];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_last = 1'b0;
    logic [9:0]  addra = '0;
    logic        cnn_done = 1'b0;
    logic [3:0]  decision_in = '0;

    logic        s_ready, cnn_rst_n, result_valid, err_short, err_timeout;
    logic [7:0]  douta;
    logic [3:0]  result;
    logic [15:0] frames_done;
    logic        w_s_ready, w_cnn_rst_n, w_result_valid, w_err_short, w_err_timeout;
    logic [7:0]  w_douta;
    logic [3:0]  w_result;
    logic [15:0] w_frames_done;

    int passed = 0;
    int total  = 0;

    frame_t fq[$];
    frame_t f;
    int     exp_frames;

    always #5 clk = ~clk;

    pixel_frame_server #(.WDOG(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .addra(addra), .douta(douta), .cnn_rst_n(cnn_rst_n),
        .cnn_done(cnn_done), .decision_in(decision_in), .result_valid(result_valid),
        .result(result), .err_short(err_short), .err_timeout(err_timeout),
        .frames_done(frames_done)
    );

    pixel_frame_server #(.WDOG(WDOG_T)) u_wdog (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(w_s_ready), .addra(addra), .douta(w_douta), .cnn_rst_n(w_cnn_rst_n),
        .cnn_done(cnn_done), .decision_in(decision_in), .result_valid(w_result_valid),
        .result(w_result), .err_short(w_err_short), .err_timeout(w_err_timeout),
        .frames_done(w_frames_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; cnn_done = 1'b0;
        repeat (3) tick;
        rst_n = 1'b1;
        tick;
        fq.delete();
        exp_frames = 0;
    endtask

    // Streams n beats; a stall beyond the budget is recorded as a failed comparison.
    task automatic send_frame(input int n, input bit ramp, input bit use_w, input bit with_last,
                              output frame_t fr);
        logic [7:0] d;
        int wt;
        for (int i = 0; i < n; i++) begin
            d = ramp ? 8'(i) : 8'($urandom);
            if (i < NPIX) fr[i] = d;
            s_valid = 1'b1; s_data = d; s_last = with_last && (i == n - 1);
            wt = 0;
            while (!(use_w ? w_s_ready : s_ready) && wt < 4000) begin tick; wt++; end
            if (wt >= 4000) begin
                total++;
                $display("FAIL stream_stall: beat %0d ready=0 required 1", i);
                s_valid = 1'b0; s_last = 1'b0;
                return;
            end
            tick;
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic pulse_done(input logic [3:0] dec);
        cnn_done = 1'b1; decision_in = dec;
        tick;
        cnn_done = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick;
        total++;
        if ({cnn_rst_n, s_ready, douta, result_valid, frames_done} !== 27'd0)
            $display("FAIL reset_outputs: got rst=%b rdy=%b dout=%h rv=%b fd=%0d required all 0",
                     cnn_rst_n, s_ready, douta, result_valid, frames_done);
        else passed++;
        rst_n = 1'b1;
        tick;
        total++;
        if (s_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", s_ready);
        else passed++;
    endtask

    task automatic test_single_frame;
        logic [9:0] a;
        logic [7:0] e;
        do_reset;
        send_frame(NPIX, 1'b1, 1'b0, 1'b1, f); fq.push_back(f);
        total++;
        if (cnn_rst_n !== 1'b0) $display("FAIL latency_early: cnn_rst_n=%b required 0", cnn_rst_n);
        else passed++;
        tick;
        total++;
        if (cnn_rst_n !== 1'b1) $display("FAIL latency_2: cnn_rst_n=%b required 1", cnn_rst_n);
        else passed++;
        addra = 10'd300; tick;
        total++;
        if (douta !== 8'h2C) $display("FAIL read_300: got %h required 2c", douta);
        else passed++;
        for (int k = 0; k < 12; k++) begin
            a = 10'($urandom_range(0, 1023)); addra = a; tick;
            e = (a < 10'(NPIX)) ? fq[0][a] : 8'h00;
            total++;
            if (douta !== e) $display("FAIL read_rand: addr %0d got %h required %h", a, douta, e);
            else passed++;
        end
        addra = 10'd900; tick;
        total++;
        if (douta !== 8'h00) $display("FAIL read_oob: got %h required 00", douta);
        else passed++;
        addra = 10'd5;
        pulse_done(4'd9); void'(fq.pop_front()); exp_frames++;
        total++;
        if (result_valid !== 1'b1 || result !== 4'd9 || frames_done !== 16'(exp_frames)
            || cnn_rst_n !== 1'b0)
            $display("FAIL done_capture: rv=%b res=%0d fd=%0d rst=%b required 1 9 %0d 0",
                     result_valid, result, frames_done, exp_frames, cnn_rst_n);
        else passed++;
        for (int k = 0; k < RST_HOLD; k++) begin
            tick;
            total++;
            if (cnn_rst_n !== 1'b0 || result_valid !== 1'b0 || douta !== 8'h00)
                $display("FAIL hold_low: rst=%b rv=%b dout=%h required 0 0 00",
                         cnn_rst_n, result_valid, douta);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] a;
        logic [3:0] dec;
        int n;
        do_reset;
        send_frame(NPIX, 1'b0, 1'b0, 1'b1, f); fq.push_back(f);
        send_frame(NPIX, 1'b0, 1'b0, 1'b1, f); fq.push_back(f);
        total++;
        if (s_ready !== 1'b0) $display("FAIL b2b_stall: s_ready=%b required 0", s_ready);
        else passed++;
        s_valid = 1'b1; s_data = 8'hA5;
        repeat (5) tick;
        s_valid = 1'b0;
        total++;
        if (s_ready !== 1'b0) $display("FAIL b2b_stall_hold: s_ready=%b required 0", s_ready);
        else passed++;
        for (int fr = 0; fr < 3; fr++) begin
            for (int k = 0; k < 6; k++) begin
                a = 10'($urandom_range(0, NPIX - 1)); addra = a; tick;
                total++;
                if (douta !== fq[0][a])
                    $display("FAIL b2b_read: frame %0d addr %0d got %h required %h",
                             fr, a, douta, fq[0][a]);
                else passed++;
            end
            dec = 4'($urandom_range(0, 15));
            pulse_done(dec); void'(fq.pop_front()); exp_frames++;
            total++;
            if (result !== dec || frames_done !== 16'(exp_frames))
                $display("FAIL b2b_done: res=%0d fd=%0d required %0d %0d",
                         result, frames_done, dec, exp_frames);
            else passed++;
            if (fr == 0) begin
                total++;
                if (s_ready !== 1'b1) $display("FAIL b2b_free: s_ready=%b required 1", s_ready);
                else passed++;
                n = 0;
                while (!cnn_rst_n && n < 50) begin n++; tick; end
                total++;
                if (n != RST_HOLD + 1)
                    $display("FAIL b2b_gap: low %0d cycles required %0d", n, RST_HOLD + 1);
                else passed++;
            end
            if (fr == 1) begin
                total++;
                if (fq.size() != 0) $display("FAIL b2b_model: queue %0d required 0", fq.size());
                else passed++;
                send_frame(NPIX, 1'b0, 1'b0, 1'b1, f); fq.push_back(f);
                tick;
            end
            if (fr < 2) begin
                n = 0;
                while (!cnn_rst_n && n < 50) begin n++; tick; end
                if (n >= 50) begin
                    total++;
                    $display("FAIL b2b_run_timeout: cnn_rst_n=0 required 1");
                end
            end
        end
    endtask

    task automatic test_short_frame;
        logic [9:0] a;
        do_reset;
        send_frame(101, 1'b0, 1'b0, 1'b1, f);
        total++;
        if (err_short !== 1'b1) $display("FAIL short_pulse: err_short=%b required 1", err_short);
        else passed++;
        tick;
        total++;
        if (err_short !== 1'b0) $display("FAIL short_width: err_short=%b required 0", err_short);
        else passed++;
        repeat (4) tick;
        total++;
        if (cnn_rst_n !== 1'b0) $display("FAIL short_norun: cnn_rst_n=%b required 0", cnn_rst_n);
        else passed++;
        send_frame(NPIX, 1'b0, 1'b0, 1'b1, f); fq.push_back(f);
        tick;
        total++;
        if (cnn_rst_n !== 1'b1) $display("FAIL short_recover: cnn_rst_n=%b required 1", cnn_rst_n);
        else passed++;
        for (int k = 0; k < 6; k++) begin
            a = (k == 0) ? 10'd0 : 10'($urandom_range(0, NPIX - 1)); addra = a; tick;
            total++;
            if (douta !== fq[0][a])
                $display("FAIL short_read: addr %0d got %h required %h", a, douta, fq[0][a]);
            else passed++;
        end
        pulse_done(4'd3);
    endtask

    task automatic test_watchdog;
        logic [3:0] dec;
        logic [9:0] a;
        int n, high, rv, t0;
        do_reset;
        send_frame(NPIX, 1'b0, 1'b1, 1'b1, f);
        repeat (2) tick;
        dec = 4'($urandom_range(1, 15));
        pulse_done(dec);
        send_frame(NPIX, 1'b0, 1'b1, 1'b1, f);
        n = 0; high = 0; rv = 0; t0 = 0;
        while (!w_err_timeout && n < 200) begin
            tick; n++;
            if (w_cnn_rst_n) high++;
            if (w_result_valid) rv++;
            if (err_timeout) t0++;
        end
        total++;
        if (n >= 200 || high != WDOG_T)
            $display("FAIL wdog_cycles: run %0d cycles (seen=%0d) required %0d",
                     high, n < 200, WDOG_T);
        else passed++;
        total++;
        if (w_result !== dec || w_frames_done !== 16'd1 || rv != 0 || w_cnn_rst_n !== 1'b0)
            $display("FAIL wdog_state: res=%0d fd=%0d rv=%0d rst=%b required %0d 1 0 0",
                     w_result, w_frames_done, rv, w_cnn_rst_n, dec);
        else passed++;
        total++;
        if (t0 != 0 || cnn_rst_n !== 1'b1)
            $display("FAIL wdog_disabled: timeouts %0d rst=%b required 0 1", t0, cnn_rst_n);
        else passed++;
        tick;
        total++;
        if (w_err_timeout !== 1'b0) $display("FAIL wdog_width: err=%b required 0", w_err_timeout);
        else passed++;
        send_frame(NPIX, 1'b0, 1'b1, 1'b1, f);
        tick;
        total++;
        if (w_cnn_rst_n !== 1'b1 || w_s_ready !== 1'b1)
            $display("FAIL wdog_freed: rst=%b rdy=%b required 1 1", w_cnn_rst_n, w_s_ready);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            a = 10'($urandom_range(0, NPIX - 1)); addra = a; tick;
            total++;
            if (w_douta !== f[a])
                $display("FAIL wdog_read: addr %0d got %h required %h", a, w_douta, f[a]);
            else passed++;
        end
    endtask

    task automatic test_done_level_and_reset;
        logic [9:0] a;
        int rv;
        do_reset;
        send_frame(NPIX, 1'b0, 1'b0, 1'b1, f);
        repeat (2) tick;
        cnn_done = 1'b1; decision_in = 4'd7; rv = 0;
        repeat (10) begin tick; if (result_valid) rv++; end
        cnn_done = 1'b0;
        repeat (10) begin tick; if (result_valid) rv++; end
        total++;
        if (rv != 1 || frames_done !== 16'd1 || result !== 4'd7)
            $display("FAIL done_level: pulses %0d fd=%0d res=%0d required 1 1 7",
                     rv, frames_done, result);
        else passed++;
        send_frame(NPIX, 1'b0, 1'b0, 1'b1, f);
        tick;
        send_frame(300, 1'b0, 1'b0, 1'b0, f);
        rst_n = 1'b0; rv = 0;
        repeat (2) begin tick; if (result_valid) rv++; end
        total++;
        if (cnn_rst_n !== 1'b0 || s_ready !== 1'b0 || frames_done !== 16'd0)
            $display("FAIL midrun_reset: rst=%b rdy=%b fd=%0d required 0 0 0",
                     cnn_rst_n, s_ready, frames_done);
        else passed++;
        rst_n = 1'b1;
        repeat (10) begin tick; if (result_valid) rv++; end
        total++;
        if (rv != 0 || cnn_rst_n !== 1'b0 || s_ready !== 1'b1)
            $display("FAIL midrun_after: rv=%0d rst=%b rdy=%b required 0 0 1",
                     rv, cnn_rst_n, s_ready);
        else passed++;
        send_frame(NPIX, 1'b0, 1'b0, 1'b1, f);
        tick;
        for (int k = 0; k < 4; k++) begin
            a = (k == 0) ? 10'd0 : (k == 1) ? 10'(NPIX - 1) : 10'($urandom_range(0, NPIX - 1));
            addra = a; tick;
            total++;
            if (douta !== f[a])
                $display("FAIL midrun_read: addr %0d got %h required %h", a, douta, f[a]);
            else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_short_frame;
        test_watchdog;
        test_done_level_and_reset;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
